// File: rtl/ram_partition_ctrl.sv
// Sequencer for a partitioned, power-gated RAM. It runs the full-array init after reset.
// On request it drains accesses, regates the partitions, and re-initializes the ones that come back on.
//
// state     | meaning
// INIT_ALL  | writing every row after reset
// IDLE      | normal operation, accepting configuration requests
// DRAIN     | waiting for outstanding accesses to finish
// INIT_PART | writing the rows of newly enabled partitions
module ram_partition_ctrl #(
    parameter int DEPTH         = 128,
    parameter int INDEX         = 7,
    parameter int WIDTH         = 8,
    parameter int NUM_PARTS     = 4,
    parameter int NUM_PARTS_LOG = 2,
    parameter int RESET_VAL     = 0,
    parameter int SEQ_START     = 34
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfgReq_i,
    input  logic [NUM_PARTS-1:0] cfgGate_i,
    input  logic                 busy_i,
    output logic                 cfgAck_o,
    output logic                 stall_o,
    output logic                 ramReady_o,
    output logic [NUM_PARTS-1:0] partitionGated_o,
    output logic                 initWrEn_o,
    output logic [INDEX-1:0]     initAddr_o,
    output logic [WIDTH-1:0]     initData_o
);
    // Rows per partition are a power of two, so a row address is {partition, offset}.
    localparam int OFF_W = INDEX - NUM_PARTS_LOG;
    localparam logic [INDEX-1:0] LAST_ROW = INDEX'(DEPTH - 1);
    localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(DEPTH / NUM_PARTS - 1);

    typedef enum logic [1:0] {INIT_ALL, IDLE, DRAIN, INIT_PART} stateType;

    stateType                 state;
    logic [INDEX-1:0]         rowCnt;
    logic [OFF_W-1:0]         rowOff;
    logic [NUM_PARTS_LOG-1:0] curPart;
    logic [NUM_PARTS-1:0]     remMask;
    logic [NUM_PARTS-1:0]     pendMask;

    logic [NUM_PARTS-1:0]     newOn;
    logic [NUM_PARTS-1:0]     remAfter;
    logic [NUM_PARTS_LOG-1:0] newOnFirst;
    logic [NUM_PARTS_LOG-1:0] remAfterFirst;
    logic [INDEX-1:0]         firstAddr;
    logic [INDEX-1:0]         curAddr;

    function automatic logic [WIDTH-1:0] initVal(input logic [INDEX-1:0] addr);
        logic [WIDTH-1:0] v;
        v = WIDTH'(SEQ_START) + WIDTH'(addr);
        return (RESET_VAL == 1) ? v : '0;
    endfunction

    function automatic logic [NUM_PARTS_LOG-1:0] lowPart(input logic [NUM_PARTS-1:0] m);
        logic [NUM_PARTS_LOG-1:0] p;
        p = '0;
        for (int i = NUM_PARTS - 1; i >= 0; i--) begin
            if (m[i]) p = NUM_PARTS_LOG'(i);
        end
        return p;
    endfunction

    always_comb begin
        newOn         = partitionGated_o & ~pendMask;
        remAfter      = remMask & ~(NUM_PARTS'(1) << curPart);
        newOnFirst    = lowPart(newOn);
        remAfterFirst = lowPart(remAfter);
        firstAddr     = {newOnFirst, OFF_W'(0)};
        curAddr       = {curPart, rowOff};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= INIT_ALL;
            rowCnt           <= '0;
            rowOff           <= '0;
            curPart          <= '0;
            remMask          <= '0;
            pendMask         <= '0;
            cfgAck_o         <= 1'b0;
            stall_o          <= 1'b1;
            ramReady_o       <= 1'b0;
            partitionGated_o <= '0;
            initWrEn_o       <= 1'b0;
            initAddr_o       <= '0;
            initData_o       <= '0;
        end else begin
            cfgAck_o <= 1'b0;
            case (state)
                INIT_ALL: begin
                    initWrEn_o <= 1'b1;
                    initAddr_o <= rowCnt;
                    initData_o <= initVal(rowCnt);
                    stall_o    <= 1'b1;
                    ramReady_o <= 1'b0;
                    if (rowCnt == LAST_ROW) begin
                        rowCnt <= '0;
                        state  <= IDLE;
                    end else begin
                        rowCnt <= rowCnt + 1'b1;
                    end
                end
                IDLE: begin
                    initWrEn_o <= 1'b0;
                    if (cfgReq_i) begin
                        // partition 0 always stays powered
                        pendMask   <= cfgGate_i & ~NUM_PARTS'(1);
                        cfgAck_o   <= 1'b1;
                        stall_o    <= 1'b1;
                        ramReady_o <= 1'b0;
                        state      <= DRAIN;
                    end else begin
                        stall_o    <= 1'b0;
                        ramReady_o <= 1'b1;
                    end
                end
                DRAIN: begin
                    stall_o    <= 1'b1;
                    ramReady_o <= 1'b0;
                    if (!busy_i) begin
                        partitionGated_o <= pendMask;
                        if (newOn == '0) begin
                            state <= IDLE;
                        end else begin
                            initWrEn_o <= 1'b1;
                            initAddr_o <= firstAddr;
                            initData_o <= initVal(firstAddr);
                            curPart    <= newOnFirst;
                            remMask    <= newOn;
                            rowOff     <= OFF_W'(1);
                            state      <= INIT_PART;
                        end
                    end
                end
                INIT_PART: begin
                    initWrEn_o <= 1'b1;
                    initAddr_o <= curAddr;
                    initData_o <= initVal(curAddr);
                    if (rowOff == LAST_OFF) begin
                        rowOff  <= '0;
                        remMask <= remAfter;
                        curPart <= remAfterFirst;
                        if (remAfter == '0) state <= IDLE;
                    end else begin
                        rowOff <= rowOff + 1'b1;
                    end
                end
                default: state <= INIT_ALL;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_partition_ctrl.sv
// Bench for ram_partition_ctrl: two instances (sequential and zero init pattern) checked every cycle
// against a queue-based model of the write schedule, plus hand-computed directed expectations.
module tb_ram_partition_ctrl;
    localparam int DEPTH = 128;
    localparam int NUM_PARTS = 4;
    localparam int R = DEPTH / NUM_PARTS;
    localparam int SEQ_START = 34;

    logic       clk;
    logic       reset;
    logic       cfgReq;
    logic [3:0] cfgGate;
    logic       busy;

    logic       ackS, stallS, readyS, wrS;
    logic [3:0] maskS;
    logic [6:0] addrS;
    logic [7:0] dataS;
    logic       ackZ, stallZ, readyZ, wrZ;
    logic [3:0] maskZ;
    logic [6:0] addrZ;
    logic [7:0] dataZ;

    int nCompared = 0;
    int nMismatch = 0;
    int ackSeen = 0;
    int wrSeen = 0;

    ram_partition_ctrl #(.RESET_VAL(1), .SEQ_START(SEQ_START)) dutSeq (
        .clk(clk), .reset(reset), .cfgReq_i(cfgReq), .cfgGate_i(cfgGate), .busy_i(busy),
        .cfgAck_o(ackS), .stall_o(stallS), .ramReady_o(readyS), .partitionGated_o(maskS),
        .initWrEn_o(wrS), .initAddr_o(addrS), .initData_o(dataS)
    );

    ram_partition_ctrl #(.RESET_VAL(0), .SEQ_START(SEQ_START)) dutZero (
        .clk(clk), .reset(reset), .cfgReq_i(cfgReq), .cfgGate_i(cfgGate), .busy_i(busy),
        .cfgAck_o(ackZ), .stall_o(stallZ), .ramReady_o(readyZ), .partitionGated_o(maskZ),
        .initWrEn_o(wrZ), .initAddr_o(addrZ), .initData_o(dataZ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatch++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: outputs follow from a queue of rows still to be written plus an operating phase.
    int         writeQ[$];
    int         phase;
    logic [3:0] mMask, mPend;
    logic       expAck, expStall, expReady, expWr, expChkAddr;
    logic [6:0] expAddr;
    bit         modelOn = 0;

    task automatic emitWrite();
        int a;
        a = writeQ.pop_front();
        expWr      = 1'b1;
        expAddr    = 7'(a);
        expChkAddr = 1'b1;
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            modelOn = 1;
            writeQ.delete();
            for (int a = 0; a < DEPTH; a++) writeQ.push_back(a);
            phase = 0;
            mMask = '0;
            mPend = '0;
            expAck = 0; expStall = 1; expReady = 0; expWr = 0;
            expAddr = '0; expChkAddr = 1;
        end else begin
            expAck = 0; expWr = 0; expChkAddr = 0;
            case (phase)
                0: begin
                    emitWrite();
                    expStall = 1; expReady = 0;
                    if (writeQ.size() == 0) phase = 1;
                end
                1: begin
                    if (cfgReq) begin
                        mPend = cfgGate & 4'b1110;
                        expAck = 1; expStall = 1; expReady = 0;
                        phase = 2;
                    end else begin
                        expStall = 0; expReady = 1;
                    end
                end
                default: begin
                    expStall = 1; expReady = 0;
                    if (!busy) begin
                        for (int p = 0; p < NUM_PARTS; p++)
                            if (mMask[p] && !mPend[p])
                                for (int r = 0; r < R; r++) writeQ.push_back(p * R + r);
                        mMask = mPend;
                        if (writeQ.size() > 0) begin
                            emitWrite();
                            phase = (writeQ.size() > 0) ? 0 : 1;
                        end else begin
                            phase = 1;
                        end
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (modelOn) begin
            check("ack_seq", ackS, expAck);
            check("stall_seq", stallS, expStall);
            check("ready_seq", readyS, expReady);
            check("mask_seq", maskS, mMask);
            check("wren_seq", wrS, expWr);
            check("ack_zero", ackZ, expAck);
            check("stall_zero", stallZ, expStall);
            check("ready_zero", readyZ, expReady);
            check("mask_zero", maskZ, mMask);
            check("wren_zero", wrZ, expWr);
            if (expChkAddr) begin
                check("addr_seq", addrS, expAddr);
                check("addr_zero", addrZ, expAddr);
                check("data_seq", dataS, expWr ? ((SEQ_START + int'(expAddr)) % 256) : 0);
                check("data_zero", dataZ, 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (ackS) ackSeen++;
        if (wrZ) wrSeen++;
    endtask

    task automatic checkResetValues(input string tag);
        check({tag, "_stall"}, stallS, 1);
        check({tag, "_ready"}, readyS, 0);
        check({tag, "_ack"}, ackS, 0);
        check({tag, "_mask"}, maskS, 0);
        check({tag, "_wren"}, wrS, 0);
        check({tag, "_addr"}, addrS, 0);
        check({tag, "_data"}, dataS, 0);
    endtask

    initial begin
        reset = 1'b0; cfgReq = 1'b0; cfgGate = 4'b0000; busy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkResetValues("rst0");

        // Full init after reset
        @(negedge clk);
        reset = 1'b1;
        ackSeen = 0; wrSeen = 0;
        tick();
        check("init_first_wren", wrS, 1);
        check("init_first_addr", addrS, 7'h00);
        check("init_first_data", dataS, 8'h22);
        check("init_first_zero", dataZ, 8'h00);
        repeat (127) tick();
        check("init_last_addr", addrS, 7'h7F);
        check("init_last_data", dataS, 8'hA1);
        check("init_last_ready", readyS, 0);
        tick();
        check("init_ready", readyS, 1);
        check("init_stall", stallS, 0);
        check("init_no_ack", ackSeen, 0);
        check("init_writes", wrSeen, 128);

        // 0000 -> 1100, nothing comes back on
        cfgReq = 1'b1; cfgGate = 4'b1100;
        tick();
        check("r1_ack", ackS, 1);
        check("r1_stall", stallS, 1);
        check("r1_ready", readyS, 0);
        cfgReq = 1'b0;
        tick();
        check("r1_mask", maskS, 4'b1100);
        check("r1_wren", wrS, 0);
        check("r1_ack_gone", ackS, 0);
        tick();
        check("r1_ready_back", readyS, 1);

        // 1100 -> 1110
        cfgReq = 1'b1; cfgGate = 4'b1110;
        tick();
        cfgReq = 1'b0;
        tick();
        check("r2_mask", maskS, 4'b1110);
        tick();

        // 1110 -> 1000 under a 5-cycle drain: partitions 1 and 2 re-initialized
        cfgReq = 1'b1; cfgGate = 4'b1000; busy = 1'b1;
        tick();
        check("r3_ack", ackS, 1);
        cfgReq = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("r3_drain_stall", stallS, 1);
            check("r3_drain_mask", maskS, 4'b1110);
        end
        busy = 1'b0;
        wrSeen = 0;
        tick();
        check("r3_mask", maskS, 4'b1000);
        check("r3_first_addr", addrS, 7'h20);
        check("r3_first_zero", dataZ, 8'h00);
        check("r3_first_seq", dataS, 8'h42);
        repeat (63) tick();
        check("r3_last_addr", addrZ, 7'h5F);
        check("r3_last_seq", dataS, 8'h81);
        check("r3_writes", wrSeen, 64);
        tick();
        check("r3_ready", readyS, 1);
        check("r3_wren_off", wrZ, 0);

        // 1111 requested: partition 0 stays on
        cfgReq = 1'b1; cfgGate = 4'b1111;
        tick();
        check("r4_ack", ackS, 1);
        cfgReq = 1'b0;
        tick();
        check("r4_mask", maskS, 4'b1110);
        tick();

        // 1110 -> 0000, reset lands mid re-init at row 0x30
        cfgReq = 1'b1; cfgGate = 4'b0000;
        tick();
        cfgReq = 1'b0;
        tick();
        check("r5_first_addr", addrS, 7'h20);
        repeat (16) tick();
        check("r5_mid_addr", addrS, 7'h30);
        reset = 1'b0;
        cfgReq = 1'b1; cfgGate = 4'b0100;
        #1;
        checkResetValues("rst1");
        tick();
        tick();

        // Request held through the whole init is accepted once, after it
        @(negedge clk);
        reset = 1'b1;
        ackSeen = 0;
        tick();
        check("reinit_addr", addrS, 7'h00);
        check("reinit_wren", wrS, 1);
        check("reinit_mask", maskS, 4'b0000);
        repeat (127) tick();
        check("held_no_early_ack", ackSeen, 0);
        tick();
        check("held_ack", ackS, 1);
        cfgReq = 1'b0;
        tick();
        check("held_mask", maskS, 4'b0100);
        check("held_wren", wrS, 0);
        tick();
        check("held_ready", readyS, 1);
        check("held_one_ack", ackSeen, 1);
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule

// File: doc/ram_partition_ctrl.md
# ram_partition_ctrl

Configuration sequencer for a partitioned, power-gated RAM_CONFIGURABLE instance. On request it drains in-flight accesses, updates the partition gating mask, and re-initializes every newly enabled partition through one dedicated write port. It also runs the full-array initialization after reset and drives the RAM's ready/stall status to the requesting pipeline stages.

## Interface
- DEPTH, 128, total RAM rows
- INDEX, 7, address width (log2 DEPTH)
- WIDTH, 8, data width
- NUM_PARTS, 4, number of partitions; DEPTH divisible by NUM_PARTS; rows per partition R = DEPTH/NUM_PARTS
- NUM_PARTS_LOG, 2, log2 NUM_PARTS
- RESET_VAL, 0, init pattern: 0 = zero, 1 = sequential
- SEQ_START, 34, first value of the sequential pattern
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- cfgReq_i  in  1  configuration request, level; requester holds until cfgAck_o
- cfgGate_i  in  NUM_PARTS  requested gating mask, 1 = partition off; sampled with cfgReq_i
- busy_i  in  1  accesses outstanding in the RAM pipeline
- cfgAck_o  out  1  one-cycle acknowledge of an accepted request
- stall_o  out  1  requesters must not issue RAM accesses
- ramReady_o  out  1  RAM contents valid, normal operation
- partitionGated_o  out  NUM_PARTS  gating mask to RAM partitionGated_i
- initWrEn_o  out  1  init write enable to the dedicated write port
- initAddr_o  out  INDEX  init write address
- initData_o  out  WIDTH  init write data

## Operation
- States: INIT_ALL, IDLE, DRAIN, INIT_PART. All outputs are registered.
- Reset asserted (any time, including mid-sequence): state INIT_ALL with row counter 0; ramReady_o=0, stall_o=1, cfgAck_o=0, partitionGated_o=0, initWrEn_o=0, initAddr_o=0, initData_o=0. Any in-progress sequence is abandoned and the mask is restored to all-on.
- INIT_ALL: writes rows 0..DEPTH-1, one per cycle, ascending; stall_o=1. After row DEPTH-1 -> IDLE.
- IDLE: ramReady_o=1, stall_o=0, initWrEn_o=0. If cfgReq_i=1: latch mask M = cfgGate_i with bit 0 forced to 0 (partition 0 is never gated), pulse cfgAck_o, go to DRAIN.
- DRAIN: stall_o=1, ramReady_o=0. Stays while busy_i=1. On the first cycle with busy_i=0: partitionGated_o <= M; newly enabled set E = old mask & ~M. If E=0 -> IDLE, else -> INIT_PART.
- INIT_PART: for each partition p in E, ascending p, writes rows p*R..p*R+R-1 ascending, one per cycle, back to back. Partitions not in E are never written. Newly gated partitions lose their contents and are not saved. After the last row -> IDLE.
- Init data: RESET_VAL=0 gives 0. RESET_VAL=1 gives (SEQ_START + addr) mod 2^WIDTH.
- cfgReq_i outside IDLE is ignored with no ack. A held request is accepted on the first IDLE cycle.
- If M equals the current mask, the controller still acks and drains, then makes no writes and returns to IDLE.

## Timing
- Reset release, edge 1: first write (addr 0). Edge k: addr k-1. Edge DEPTH+1: IDLE, ramReady_o=1, stall_o=0.
- cfgReq_i=1 sampled in IDLE at edge N: edge N+1 gives cfgAck_o=1 for one cycle, stall_o=1, ramReady_o=0.
- busy_i=0 sampled in DRAIN at edge M: edge M+1 updates partitionGated_o, and if E is non-empty the first init write is valid in the same cycle.
- With |E| = k: writes occupy k*R consecutive cycles. ramReady_o rises one cycle after the last write.
- Minimum reconfiguration with no init: ramReady_o is low for 2 cycles (DRAIN entered, then exit to IDLE).

## Test plan
- RESET_VAL=1, SEQ_START=34, defaults: release reset -> 128 writes, addr 0x00..0x7F, data 0x22..0xA1; ramReady_o=1 at edge 129; no ack issued.
- In IDLE with mask 0000, request 1100, busy_i=0 -> cfgAck_o pulse at N+1; partitionGated_o=1100 at N+2; no writes; ramReady_o=1 at N+3.
- Mask 1110, request 1000, busy_i high 5 cycles -> stall_o held and mask unchanged through the busy period; then mask 1000 and 64 writes, addr 0x20..0x5F, data 0; then ramReady_o=1.
- Request 1111 -> latched mask 1110; partition 0 stays on.
- Hold cfgReq_i through INIT_ALL -> no ack until IDLE; ack on the first IDLE cycle + 1; exactly one ack per accepted request.
- Assert reset during INIT_PART at addr 0x30 -> all outputs return to reset values immediately; after release, full INIT_ALL from addr 0 with mask 0000.
